// File: rtl/demux_1_to_3_8_reg_if.sv
// Bus bundle for the registered 1-to-3 demultiplexer: write-side controls in,
// held destination words and status out.
interface demux_1_to_3_8_reg_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             sel_first;
  logic             sel_second;
  logic             sel_third;
  logic             clr_err;
  logic [WIDTH-1:0] out_first;
  logic [WIDTH-1:0] out_second;
  logic [WIDTH-1:0] out_third;
  logic             upd_first;
  logic             upd_second;
  logic             upd_third;
  logic             multi_sel_err;
  logic [CNT_W-1:0] drop_cnt;

  modport master (
    output in_data, in_valid, sel_first, sel_second, sel_third, clr_err,
    input  out_first, out_second, out_third, upd_first, upd_second, upd_third,
           multi_sel_err, drop_cnt
  );

  modport slave (
    input  in_data, in_valid, sel_first, sel_second, sel_third, clr_err,
    output out_first, out_second, out_third, upd_first, upd_second, upd_third,
           multi_sel_err, drop_cnt
  );
endinterface

// File: rtl/demux_1_to_3_8_reg.sv
// Registered 1-to-3 demultiplexer with hold: steers one word into one of three
// holding registers by priority-resolved one-hot select and flags bad selects.
module demux_1_to_3_8_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  demux_1_to_3_8_reg_if.slave  bus
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic any_sel;
  logic multi_sel;

  always_comb begin
    any_sel   = bus.sel_first | bus.sel_second | bus.sel_third;
    multi_sel = (bus.sel_first & bus.sel_second) | (bus.sel_first & bus.sel_third) |
                (bus.sel_second & bus.sel_third);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_first     <= '0;
      bus.out_second    <= '0;
      bus.out_third     <= '0;
      bus.upd_first     <= 1'b0;
      bus.upd_second    <= 1'b0;
      bus.upd_third     <= 1'b0;
      bus.multi_sel_err <= 1'b0;
      bus.drop_cnt      <= '0;
    end else begin
      bus.upd_first  <= 1'b0;
      bus.upd_second <= 1'b0;
      bus.upd_third  <= 1'b0;

      if (bus.in_valid) begin
        if (bus.sel_first) begin
          bus.out_first <= bus.in_data;
          bus.upd_first <= 1'b1;
        end else if (bus.sel_second) begin
          bus.out_second <= bus.in_data;
          bus.upd_second <= 1'b1;
        end else if (bus.sel_third) begin
          bus.out_third <= bus.in_data;
          bus.upd_third <= 1'b1;
        end
      end

      // Clear beats any error event landing on the same edge.
      if (bus.clr_err) begin
        bus.multi_sel_err <= 1'b0;
        bus.drop_cnt      <= '0;
      end else if (bus.in_valid) begin
        if (multi_sel) begin
          bus.multi_sel_err <= 1'b1;
        end
        if (!any_sel && (bus.drop_cnt != CntMax)) begin
          bus.drop_cnt <= bus.drop_cnt + 1'b1;
        end
      end
    end
  end

endmodule
